// File: rtl/pipe_fixed_point_acc.sv
// Signed fixed-point frame accumulator: sums Q(WII).(WIF) samples into a Q(WOI).(WIF)
// field, closing a frame on i_last or after MAXLEN samples, with sticky overflow flags.
module pipe_fixed_point_acc #(
    parameter int WII    = 12,
    parameter int WIF    = 6,
    parameter int WOI    = 16,
    parameter int MAXLEN = 8,
    parameter int CW     = $clog2(MAXLEN + 1),
    parameter bit ROOF   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_en,
    input  logic [WII+WIF-1:0]   i_data,
    input  logic                 i_last,
    input  logic                 i_upflow,
    input  logic                 i_downflow,
    output logic                 o_en,
    output logic [WOI+WIF-1:0]   o_data,
    output logic [CW-1:0]        o_cnt,
    output logic                 o_upflow,
    output logic                 o_downflow
);
    localparam int WI = WII + WIF;
    localparam int WO = WOI + WIF;

    logic [WO-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_q, first_d;
    logic          fup_q, fup_d;
    logic          fdn_q, fdn_d;
    logic          o_en_q, o_en_d;
    logic [WO-1:0] o_data_q, o_data_d;
    logic [CW-1:0] o_cnt_q, o_cnt_d;
    logic          o_up_q, o_up_d;
    logic          o_dn_q, o_dn_d;

    logic [WO:0]   ext;
    logic [WO-1:0] base;
    logic [WO:0]   sum;
    logic          pos_ovf, neg_ovf;
    logic [WO-1:0] result;
    logic [CW-1:0] cnt_inc;
    logic          close;
    logic          fup_now, fdn_now;

    always_comb begin
        ext     = {{(WO + 1 - WI){i_data[WI-1]}}, i_data};
        base    = first_q ? '0 : acc_q;
        sum     = {base[WO-1], base} + ext;
        pos_ovf = (sum[WO:WO-1] == 2'b01);
        neg_ovf = (sum[WO:WO-1] == 2'b10);
        if (ROOF && pos_ovf) begin
            result = {1'b0, {(WO - 1){1'b1}}};
        end else if (ROOF && neg_ovf) begin
            result = {1'b1, {(WO - 1){1'b0}}};
        end else begin
            result = sum[WO-1:0];
        end
        // Sticky flags restart with the frame, then absorb this sample's events.
        fup_now = (first_q ? 1'b0 : fup_q) | pos_ovf | i_upflow;
        fdn_now = (first_q ? 1'b0 : fdn_q) | neg_ovf | i_downflow;
        cnt_inc = cnt_q + 1'b1;
        close   = i_last | (cnt_inc == CW'(MAXLEN));

        acc_d    = acc_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        fup_d    = fup_q;
        fdn_d    = fdn_q;
        o_en_d   = 1'b0;
        o_data_d = o_data_q;
        o_cnt_d  = o_cnt_q;
        o_up_d   = o_up_q;
        o_dn_d   = o_dn_q;

        if (i_en) begin
            if (close) begin
                o_en_d   = 1'b1;
                o_data_d = result;
                o_cnt_d  = cnt_inc;
                o_up_d   = fup_now;
                o_dn_d   = fdn_now;
                first_d  = 1'b1;
                cnt_d    = '0;
            end else begin
                acc_d   = result;
                cnt_d   = cnt_inc;
                first_d = 1'b0;
                fup_d   = fup_now;
                fdn_d   = fdn_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            fup_q    <= 1'b0;
            fdn_q    <= 1'b0;
            o_en_q   <= 1'b0;
            o_data_q <= '0;
            o_cnt_q  <= '0;
            o_up_q   <= 1'b0;
            o_dn_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            fup_q    <= fup_d;
            fdn_q    <= fdn_d;
            o_en_q   <= o_en_d;
            o_data_q <= o_data_d;
            o_cnt_q  <= o_cnt_d;
            o_up_q   <= o_up_d;
            o_dn_q   <= o_dn_d;
        end
    end

    assign o_en       = o_en_q;
    assign o_data     = o_data_q;
    assign o_cnt      = o_cnt_q;
    assign o_upflow   = o_up_q;
    assign o_downflow = o_dn_q;
endmodule

// File: doc/pipe_fixed_point_acc.md
# pipe_fixed_point_acc

Pipelined signed fixed-point frame accumulator that sits directly downstream of the pipelined fixed-point multiplier. It consumes one product per enabled cycle and sums a frame of products into a wider integer field. The frame closes on `i_last` or after `MAXLEN` samples. It then emits the sum, the sample count and sticky overflow flags, so that multiply followed by accumulate forms a dot-product datapath.

## Interface
- `WII`, 12: integer bits of the input, which are the multiplier's output integer bits.
- `WIF`, 6: fractional bits of the input and of the output. The fractional width is unchanged through the block.
- `WOI`, 16: integer bits of the accumulator and output. Must satisfy `WOI >= WII`.
- `MAXLEN`, 8: maximum number of samples per frame, at least 1. The frame closes automatically when this count is reached.
- `CW`, `$clog2(MAXLEN+1)`: width of the sample-count output.
- `ROOF`, 1: overflow handling. 1 saturates at each add; 0 wraps two's-complement.
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `i_en`, input, 1: input sample valid.
- `i_data`, input, `WII+WIF`: signed sample in Q`WII`.`WIF` format.
- `i_last`, input, 1: marks the final sample of a frame. Qualified by `i_en`.
- `i_upflow`, input, 1: multiplier positive-overflow flag for this sample. Qualified by `i_en`.
- `i_downflow`, input, 1: multiplier negative-overflow flag for this sample. Qualified by `i_en`.
- `o_en`, output, 1: one-cycle pulse marking a completed frame.
- `o_data`, output, `WOI+WIF`: signed frame sum in Q`WOI`.`WIF` format.
- `o_cnt`, output, `CW`: number of samples in the completed frame, from 1 to `MAXLEN`.
- `o_upflow`, output, 1: positive overflow occurred in the frame, either in the accumulator or flagged by the upstream multiplier.
- `o_downflow`, output, 1: negative overflow occurred in the frame, from either source.

## Operation
- **Internal state**
  - `acc`: `WOI+WIF` bits.
  - `cnt`: `CW` bits.
  - `first`: 1 bit, set when a new frame starts.
  - `fup`, `fdn`: sticky overflow flags.
- **Sample cycle** (`i_en=1`)
  - Sign-extend `i_data` to `WOI+WIF+1` bits.
  - `base` is 0 if `first=1`, otherwise `acc`.
  - `sum = sext(base) + sext(i_data)`, computed at `WOI+WIF+1` bits.
- **Overflow detection**
  - Positive overflow when the top two bits of `sum` are 01. Negative overflow when they are 10.
  - `ROOF=1`: clamp the result to `0111…1` or `1000…0`.
  - `ROOF=0`: keep the low `WOI+WIF` bits.
  - Either way, set the matching sticky flag.
- **Flag merge**: `i_upflow` and `i_downflow` are OR'd into the sticky flags. The sticky flags are cleared, like `acc`, when a new frame starts (`first=1`).
- **Frame close**: the frame closes when `i_last=1` or `cnt+1 == MAXLEN`. Both together count as one close.
  - On the next edge, register `o_data` = result, `o_cnt` = `cnt+1`, and the flags, each including the current sample's contribution.
  - Pulse `o_en`.
  - Set `first=1` and `cnt=0`.
- **No close**: `acc` = result, `cnt` = `cnt+1`, `first=0`.
- **Idle cycle** (`i_en=0`): all state holds. `i_last`, `i_upflow` and `i_downflow` are ignored.
- **Saturation persistence**: with `ROOF=1`, a saturated `acc` stays clamped until later samples of opposite sign bring it back in range.

## Timing
- **Latency**: `o_en` asserts exactly 1 cycle after the closing sample's edge.
- **Throughput**: one sample per cycle with no bubbles. A new frame may start in the cycle immediately after a closing sample. That frame's output does not disturb the held `o_*` values until it closes.
- **Output hold**: `o_en` is high for 1 cycle per frame. `o_data`, `o_cnt`, `o_upflow` and `o_downflow` hold their values until the next close.
- **Reset values**: `o_en=0`, `o_data=0`, `o_cnt=0`, `o_upflow=0`, `o_downflow=0`. Internally `acc=0`, `cnt=0`, `first=1`, and the sticky flags are 0.
- **Reset mid-frame**: partial frame state is discarded and no `o_en` is produced for it. The first sample after reset release starts a new frame.
- **No backpressure**: the downstream consumer must accept every `o_en` pulse.

## Test plan
Bench parameters: `WII=12`, `WIF=6`, `WOI=14`, `MAXLEN=8`, which gives an output of 20 bits. Scenarios use `ROOF=1` unless stated.
- **Basic frame**: samples 96 (1.5), −16 (−0.25), and 128 (2.0) with `i_last` on the third. Required 1 cycle later: `o_en` pulse, `o_data=208` (3.25), `o_cnt=3`, both flags 0.
- **Gaps and ignored inputs**: same three samples with `i_en=0` gaps between them, plus `i_last=1` asserted on a gap cycle. Required: identical result, and no close on the gap cycle.
- **Auto-close**: 8 samples of 64 (1.0) with no `i_last`. Required: `o_data=512` (8.0), `o_cnt=8`. A ninth sample of 64 with `i_last` then gives `o_data=64`, `o_cnt=1`.
- **Overflow, both modes**: 8 samples of 131071 (2047.984375).
  - `ROOF=1`: `o_data=524287` (8191.984375), `o_upflow=1`.
  - `ROOF=0`: `o_data=-8` (−0.125), `o_upflow=1`.
  - Next frame: 2 samples of 64 gives 128 with both flags 0.
- **Back-to-back frames and upstream flag**:
  - Frame A is a single sample of 64 with `i_last` and `i_downflow=1`.
  - Frame B is the immediately following samples 32 and 32, with `i_last` on the second.
  - Required: frame A gives `o_data=64`, `o_downflow=1`, `o_cnt=1`. Frame B gives `o_data=64`, `o_downflow=0`, `o_cnt=2`.
- **Reset mid-frame**: 3 samples of 64, then `rstn` pulsed low asynchronously. Required: all outputs go to 0 immediately and no `o_en` is produced. After release, 1 sample of 64 with `i_last` gives `o_data=64`, `o_cnt=1`.
